// File: rtl/cursor_repeat_ctrl.sv
// Board-cursor controller with typematic auto-repeat.
// Converts a single held direction button into one immediate cursor step,
// a first repeat after DELAY cycles and further repeats every RATE cycles.
// The cursor position, the position before the last move, the move strobe
// and the busy flag are all registered.
module cursor_repeat_ctrl #(
  parameter int COLS   = 8,
  parameter int ROWS   = 8,
  parameter int XW     = 3,
  parameter int YW     = 3,
  parameter int DELAY  = 25_000_000,
  parameter int RATE   = 6_250_000,
  parameter int WRAP   = 0,
  parameter int INIT_X = 0,
  parameter int INIT_Y = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          clear,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          btn_right,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [XW-1:0] prev_x,
  output logic [YW-1:0] prev_y,
  output logic          moved,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DELAY    = 2'd1,
    ST_REPEAT   = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam logic [27:0]   DELAY_LD = 28'(DELAY - 1);
  localparam logic [27:0]   RATE_LD  = 28'(RATE - 1);
  localparam logic [XW-1:0] X_MAX    = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX    = YW'(ROWS - 1);
  localparam logic [XW-1:0] X_ZERO   = {XW{1'b0}};
  localparam logic [YW-1:0] Y_ZERO   = {YW{1'b0}};
  localparam logic [XW-1:0] X_INIT   = XW'(INIT_X);
  localparam logic [YW-1:0] Y_INIT   = YW'(INIT_Y);
  localparam logic          WRAP_EN  = (WRAP != 0);

  state_t        state_r, state_s;
  dir_t          dir_r, dir_s, press_dir_s;
  logic [27:0]   cnt_r, cnt_s;
  logic [3:0]    btn_s;
  logic          valid_s;
  logic          step_s;
  logic          step_ok_s;
  logic [XW-1:0] tgt_x_s, x_r, prev_x_r;
  logic [YW-1:0] tgt_y_s, y_r, prev_y_r;
  logic          moved_r, busy_r;

  // Decode the button levels into a single valid press and its direction.
  always_comb begin
    btn_s       = {btn_right, btn_left, btn_down, btn_up};
    valid_s     = (btn_s != 4'b0000) && ((btn_s & (btn_s - 4'd1)) == 4'b0000);
    press_dir_s = DIR_UP;
    case (btn_s)
      4'b0001: press_dir_s = DIR_UP;
      4'b0010: press_dir_s = DIR_DOWN;
      4'b0100: press_dir_s = DIR_LEFT;
      4'b1000: press_dir_s = DIR_RIGHT;
      default: press_dir_s = DIR_UP;
    endcase
  end

  // Next-state, repeat counter and step-request logic of the repeat FSM.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    dir_s   = dir_r;
    step_s  = 1'b0;
    if (clear) begin
      state_s = ST_WAIT_REL;
      cnt_s   = 28'd0;
    end else if (!enable) begin
      state_s = ST_WAIT_REL;
      cnt_s   = 28'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (valid_s) begin
            step_s  = 1'b1;
            dir_s   = press_dir_s;
            cnt_s   = DELAY_LD;
            state_s = ST_DELAY;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (valid_s && (press_dir_s == dir_r)) begin
            if (cnt_r == 28'd0) begin
              step_s  = 1'b1;
              cnt_s   = RATE_LD;
              state_s = ST_REPEAT;
            end else begin
              cnt_s = cnt_r - 28'd1;
            end
          end else begin
            // Release or a different press ends the hold without a step.
            state_s = ST_IDLE;
            cnt_s   = 28'd0;
          end
        end
        ST_WAIT_REL: begin
          if (btn_s == 4'b0000) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_WAIT_REL;
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = 28'd0;
        end
      endcase
    end
  end

  // Target cell of a step in the active direction and whether the edge allows it.
  always_comb begin
    tgt_x_s   = x_r;
    tgt_y_s   = y_r;
    step_ok_s = 1'b0;
    case (dir_s)
      DIR_UP: begin
        if (y_r == Y_ZERO) begin
          tgt_y_s   = Y_MAX;
          step_ok_s = WRAP_EN;
        end else begin
          tgt_y_s   = y_r - YW'(1);
          step_ok_s = 1'b1;
        end
      end
      DIR_DOWN: begin
        if (y_r == Y_MAX) begin
          tgt_y_s   = Y_ZERO;
          step_ok_s = WRAP_EN;
        end else begin
          tgt_y_s   = y_r + YW'(1);
          step_ok_s = 1'b1;
        end
      end
      DIR_LEFT: begin
        if (x_r == X_ZERO) begin
          tgt_x_s   = X_MAX;
          step_ok_s = WRAP_EN;
        end else begin
          tgt_x_s   = x_r - XW'(1);
          step_ok_s = 1'b1;
        end
      end
      DIR_RIGHT: begin
        if (x_r == X_MAX) begin
          tgt_x_s   = X_ZERO;
          step_ok_s = WRAP_EN;
        end else begin
          tgt_x_s   = x_r + XW'(1);
          step_ok_s = 1'b1;
        end
      end
      default: begin
        step_ok_s = 1'b0;
      end
    endcase
  end

  // FSM state, latched direction and repeat counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      dir_r   <= DIR_UP;
      cnt_r   <= 28'd0;
    end else begin
      state_r <= state_s;
      dir_r   <= dir_s;
      cnt_r   <= cnt_s;
    end
  end

  // Registered cursor position, previous position, move strobe and busy flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_r      <= X_INIT;
      y_r      <= Y_INIT;
      prev_x_r <= X_INIT;
      prev_y_r <= Y_INIT;
      moved_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else if (clear) begin
      x_r      <= X_INIT;
      y_r      <= Y_INIT;
      prev_x_r <= X_INIT;
      prev_y_r <= Y_INIT;
      moved_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      moved_r <= step_s && step_ok_s;
      busy_r  <= (state_s == ST_DELAY) || (state_s == ST_REPEAT);
      if (step_s && step_ok_s) begin
        prev_x_r <= x_r;
        prev_y_r <= y_r;
        x_r      <= tgt_x_s;
        y_r      <= tgt_y_s;
      end
    end
  end

  assign x      = x_r;
  assign y      = y_r;
  assign prev_x = prev_x_r;
  assign prev_y = prev_y_r;
  assign moved  = moved_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_cursor_repeat_ctrl.sv
// Self-checking bench for cursor_repeat_ctrl: a clamping and a wrapping
// instance share all inputs and are compared every cycle against a
// behavioural model that counts how long a press has been held.
module tb_cursor_repeat_ctrl;

  localparam int COLS  = 8;
  localparam int ROWS  = 8;
  localparam int DELAY = 10;
  localparam int RATE  = 4;

  logic clk, reset_n, enable, clear;
  logic btn_up, btn_down, btn_left, btn_right;
  logic [2:0] cx, cy, cpx, cpy, wx, wy, wpx, wpy;
  logic cmv, cbusy, wmv, wbusy;

  int checks = 0;
  int errors = 0;
  int pulses_c = 0;
  int pulses_w = 0;

  // Model state: press hold tracking is shared, positions per instance (0 clamp, 1 wrap)
  int mx[2], my[2], mpx[2], mpy[2], mmv[2];
  int mhold, mwait, mk;
  logic [3:0] mdir;

  cursor_repeat_ctrl #(.COLS(COLS), .ROWS(ROWS), .XW(3), .YW(3), .DELAY(DELAY),
                       .RATE(RATE), .WRAP(0), .INIT_X(0), .INIT_Y(0)) dut_clamp (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .x(cx), .y(cy), .prev_x(cpx), .prev_y(cpy), .moved(cmv), .busy(cbusy));

  cursor_repeat_ctrl #(.COLS(COLS), .ROWS(ROWS), .XW(3), .YW(3), .DELAY(DELAY),
                       .RATE(RATE), .WRAP(1), .INIT_X(0), .INIT_Y(0)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .x(wx), .y(wy), .prev_x(wpx), .prev_y(wpy), .moved(wmv), .busy(wbusy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mx[i] = 0; my[i] = 0; mpx[i] = 0; mpy[i] = 0; mmv[i] = 0;
    end
    mhold = 0; mwait = 0; mk = 0; mdir = 4'b0000;
  endtask

  // One clock edge of the reference behaviour
  task automatic model_step(input bit c, input bit e, input logic [3:0] b);
    bit step;
    int dx, dy, nx, ny;
    bit ok;
    step = 1'b0;
    if (c) begin
      for (int i = 0; i < 2; i++) begin
        mx[i] = 0; my[i] = 0; mpx[i] = 0; mpy[i] = 0; mmv[i] = 0;
      end
      mhold = 0; mwait = 1;
    end else begin
      if (!e) begin
        mhold = 0; mwait = 1;
      end else if (mwait != 0) begin
        if (b == 4'b0000) mwait = 0;
      end else if (mhold != 0) begin
        if ($countones(b) == 1 && b == mdir) begin
          mk++;
          if (mk >= DELAY && ((mk - DELAY) % RATE) == 0) step = 1'b1;
        end else begin
          mhold = 0;
        end
      end else if ($countones(b) == 1) begin
        mhold = 1; mdir = b; mk = 0; step = 1'b1;
      end
      dx = (mdir == 4'b1000) ? 1 : (mdir == 4'b0100) ? -1 : 0;
      dy = (mdir == 4'b0010) ? 1 : (mdir == 4'b0001) ? -1 : 0;
      for (int i = 0; i < 2; i++) begin
        mmv[i] = 0;
        if (step) begin
          nx = mx[i] + dx;
          ny = my[i] + dy;
          ok = 1'b1;
          if (nx < 0 || nx >= COLS || ny < 0 || ny >= ROWS) begin
            ok = (i == 1);
            nx = (nx + COLS) % COLS;
            ny = (ny + ROWS) % ROWS;
          end
          if (ok) begin
            mpx[i] = mx[i]; mpy[i] = my[i];
            mx[i] = nx; my[i] = ny; mmv[i] = 1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("clamp_x", 32'(cx), mx[0]);
    chk("clamp_y", 32'(cy), my[0]);
    chk("clamp_prev_x", 32'(cpx), mpx[0]);
    chk("clamp_prev_y", 32'(cpy), mpy[0]);
    chk("clamp_moved", 32'(cmv), mmv[0]);
    chk("clamp_busy", 32'(cbusy), mhold);
    chk("wrap_x", 32'(wx), mx[1]);
    chk("wrap_y", 32'(wy), my[1]);
    chk("wrap_prev_x", 32'(wpx), mpx[1]);
    chk("wrap_prev_y", 32'(wpy), mpy[1]);
    chk("wrap_moved", 32'(wmv), mmv[1]);
    chk("wrap_busy", 32'(wbusy), mhold);
  endtask

  // Drive one cycle of inputs, clock it, update the model and compare
  task automatic cyc(input bit c, input bit e, input logic [3:0] b);
    clear = c;
    enable = e;
    {btn_right, btn_left, btn_down, btn_up} = b;
    @(posedge clk);
    #1;
    model_step(c, e, b);
    compare_all();
    if (cmv) pulses_c++;
    if (wmv) pulses_w++;
  endtask

  task automatic tap(input logic [3:0] b);
    cyc(1'b0, 1'b1, b);
    cyc(1'b0, 1'b1, 4'b0000);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic async_reset();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_x", 32'(cx), 0);
    chk("rst_y", 32'(cy), 0);
    chk("rst_prev_x", 32'(cpx), 0);
    chk("rst_prev_y", 32'(cpy), 0);
    chk("rst_moved", 32'(cmv), 0);
    chk("rst_busy", 32'(cbusy), 0);
    chk("rst_wrap_x", 32'(wx), 0);
    model_reset();
    #1;
    reset_n = 1'b1;
  endtask

  localparam logic [3:0] B_UP = 4'b0001, B_DN = 4'b0010, B_LT = 4'b0100, B_RT = 4'b1000;

  initial begin
    logic [3:0] b;
    int len, r;
    reset_n = 1'b0; enable = 1'b1; clear = 1'b0;
    {btn_right, btn_left, btn_down, btn_up} = 4'b0000;
    model_reset();
    #3;
    chk("init_x", 32'(cx), 0);
    chk("init_busy", 32'(cbusy), 0);
    chk("init_moved", 32'(cmv), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc(1'b0, 1'b1, 4'b0000);

    // Short tap
    pulses_c = 0;
    repeat (3) cyc(1'b0, 1'b1, B_RT);
    repeat (2) cyc(1'b0, 1'b1, 4'b0000);
    chk("tap_x", 32'(cx), 1);
    chk("tap_prev_x", 32'(cpx), 0);
    chk("tap_pulses", pulses_c, 1);
    chk("tap_busy", 32'(cbusy), 0);

    // Hold down 30 edges: steps at E0, E10, E14, E18, E22, E26
    pulses_c = 0;
    repeat (30) cyc(1'b0, 1'b1, B_DN);
    chk("hold_y", 32'(cy), 6);
    chk("hold_pulses", pulses_c, 6);
    repeat (2) cyc(1'b0, 1'b1, 4'b0000);

    // Clamp at right edge
    repeat (6) tap(B_RT);
    chk("pre_clamp_x", 32'(cx), 7);
    pulses_c = 0;
    repeat (20) cyc(1'b0, 1'b1, B_RT);
    chk("clamp_edge_x", 32'(cx), 7);
    chk("clamp_edge_pulses", pulses_c, 0);
    chk("clamp_edge_busy", 32'(cbusy), 1);
    repeat (2) cyc(1'b0, 1'b1, 4'b0000);

    // Wrap around both edges
    cyc(1'b1, 1'b1, 4'b0000);
    cyc(1'b0, 1'b1, 4'b0000);
    tap(B_LT);
    chk("wrap_left_x", 32'(wx), 7);
    tap(B_RT);
    chk("wrap_right_x", 32'(wx), 0);
    chk("wrap_right_prev", 32'(wpx), 7);

    // Invalid double press
    pulses_c = 0;
    repeat (5) cyc(1'b0, 1'b1, B_UP | B_LT);
    chk("inv_pulses", pulses_c, 0);
    chk("inv_busy", 32'(cbusy), 0);
    cyc(1'b0, 1'b1, 4'b0000);

    // Clear while holding at (3,2)
    cyc(1'b1, 1'b1, 4'b0000);
    cyc(1'b0, 1'b1, 4'b0000);
    repeat (3) tap(B_RT);
    repeat (2) tap(B_DN);
    chk("at_3_2_x", 32'(cx), 3);
    chk("at_3_2_y", 32'(cy), 2);
    repeat (3) cyc(1'b0, 1'b1, B_RT);
    cyc(1'b1, 1'b1, B_RT);
    pulses_c = 0;
    repeat (5) cyc(1'b0, 1'b1, B_RT);
    chk("clr_x", 32'(cx), 0);
    chk("clr_y", 32'(cy), 0);
    chk("clr_pulses", pulses_c, 0);
    chk("clr_busy", 32'(cbusy), 0);
    cyc(1'b0, 1'b1, 4'b0000);
    cyc(1'b0, 1'b1, B_RT);
    chk("clr_repress_x", 32'(cx), 1);
    cyc(1'b0, 1'b1, 4'b0000);

    // Enable drop mid-repeat
    repeat (15) cyc(1'b0, 1'b1, B_DN);
    pulses_c = 0;
    repeat (6) cyc(1'b0, 1'b0, B_DN);
    chk("en_busy", 32'(cbusy), 0);
    repeat (12) cyc(1'b0, 1'b1, B_DN);
    chk("en_pulses", pulses_c, 0);
    cyc(1'b0, 1'b1, 4'b0000);
    cyc(1'b0, 1'b1, B_UP);
    chk("en_repress_moved", 32'(cmv), 1);

    // Reset mid-hold, button still held afterwards
    repeat (12) cyc(1'b0, 1'b1, B_RT);
    async_reset();
    cyc(1'b0, 1'b1, B_RT);
    chk("post_rst_moved", 32'(cmv), 1);
    chk("post_rst_x", 32'(cx), 1);

    // Randomised segments
    for (int seg = 0; seg < 200; seg++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        async_reset();
      end else begin
        if (r < 73) b = 4'(1 << $urandom_range(0, 3));
        else        b = 4'($urandom_range(0, 15));
        len = $urandom_range(1, 24);
        for (int k = 0; k < len; k++)
          cyc(($urandom_range(0, 79) == 0), ($urandom_range(0, 29) != 0), b);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
